// File: rtl/dram_port_arbiter_pkg.sv
// Shared types, default sizes and helpers for the two-master DRAM port arbiter.
package dram_port_arbiter_pkg;

    localparam int unsigned MEM_ADDR_BITS             = 16;
    localparam int unsigned XLEN                      = 32;
    localparam int unsigned DRAM_ARB_TIMEOUT_DEFAULT  = 1023;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    // Watchdog counter width; a disabled watchdog still gets a 1-bit counter.
    function automatic int unsigned arb_cnt_width(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/dram_arb_req_slot.sv
// One captured master request: latches a read/write pulse while not pending.
module dram_arb_req_slot
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_BITS,
    parameter int unsigned DATA_W = XLEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic                  read_en_i,
    input  logic                  write_en_i,
    input  logic [DATA_W/8-1:0]   byte_enable_i,
    input  logic [DATA_W-1:0]     write_data_i,
    input  logic                  clear_i,
    output logic                  pending_o,
    output logic [ADDR_W-1:0]     addr_o,
    output logic [DATA_W/8-1:0]   byte_enable_o,
    output logic [DATA_W-1:0]     write_data_o,
    output logic                  is_write_o
);

    localparam int unsigned BE_W = DATA_W / 8;

    logic              pending_q, pending_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BE_W-1:0]   be_q, be_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              is_write_q, is_write_d;
    logic              capture_c;

    // Capture a new pulse only when idle; a write wins over a simultaneous read.
    always_comb begin
        pending_d  = pending_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        capture_c  = !pending_q && (read_en_i || write_en_i);

        if (capture_c) begin
            pending_d  = 1'b1;
            addr_d     = addr_i;
            be_d       = byte_enable_i;
            wdata_d    = write_data_i;
            is_write_d = write_en_i;
        end else if (clear_i) begin
            pending_d  = 1'b0;
        end

        if (sync_reset) begin
            pending_d  = 1'b0;
            addr_d     = '0;
            be_d       = '0;
            wdata_d    = '0;
            is_write_d = 1'b0;
        end
    end

    // Slot registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_q  <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            is_write_q <= 1'b0;
        end else begin
            pending_q  <= pending_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
        end
    end

    assign pending_o     = pending_q;
    assign addr_o        = addr_q;
    assign byte_enable_o = be_q;
    assign write_data_o  = wdata_q;
    assign is_write_o    = is_write_q;

endmodule

// File: rtl/dram_port_arbiter.sv
// Round-robin arbiter sharing one DRAM port between two masters, with watchdog.
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DRAM_ARB_TIMEOUT_DEFAULT,
    parameter int unsigned ADDR_W         = MEM_ADDR_BITS,
    parameter int unsigned DATA_W         = XLEN
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sync_reset,

    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic                  m0_read_en,
    input  logic                  m0_write_en,
    input  logic [DATA_W/8-1:0]   m0_byte_enable,
    input  logic [DATA_W-1:0]     m0_write_data,
    output logic                  m0_pending,
    output logic                  m0_ack,
    output logic                  m0_err,
    output logic [DATA_W-1:0]     m0_read_data,

    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic                  m1_read_en,
    input  logic                  m1_write_en,
    input  logic [DATA_W/8-1:0]   m1_byte_enable,
    input  logic [DATA_W-1:0]     m1_write_data,
    output logic                  m1_pending,
    output logic                  m1_ack,
    output logic                  m1_err,
    output logic [DATA_W-1:0]     m1_read_data,

    input  logic                  dram_ack,
    input  logic [DATA_W-1:0]     dram_mem_read_data,
    output logic [ADDR_W-1:0]     dram_mem_addr,
    output logic                  dram_mem_read_en,
    output logic                  dram_mem_write_en,
    output logic [DATA_W/8-1:0]   dram_mem_byte_enable,
    output logic [DATA_W-1:0]     dram_mem_write_data,
    output logic                  busy
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = arb_cnt_width(TIMEOUT_CYCLES);
    localparam bit               TO_EN   = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] TO_MAX  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = TO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    // Slot outputs, indexed by master.
    logic [1:0]             s_pend;
    logic [1:0]             s_is_wr;
    logic [ADDR_W-1:0]      s_addr [2];
    logic [1:0][BE_W-1:0]   s_be;
    logic [1:0][DATA_W-1:0] s_wdata;

    arb_state_t             state_q, state_d;
    logic                   grant_q, grant_d;
    logic                   last_grant_q, last_grant_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [BE_W-1:0]        be_q, be_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic                   rd_en_q, rd_en_d;
    logic                   wr_en_q, wr_en_d;
    logic                   busy_q, busy_d;
    logic [1:0]             ack_q, ack_d;
    logic [1:0]             err_q, err_d;
    logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

    logic [1:0]             req_c;
    logic                   pick_c;
    logic                   complete_c;
    logic                   timeout_c;

    dram_arb_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot0 (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .addr_i        (m0_addr),
        .read_en_i     (m0_read_en),
        .write_en_i    (m0_write_en),
        .byte_enable_i (m0_byte_enable),
        .write_data_i  (m0_write_data),
        .clear_i       (ack_q[0]),
        .pending_o     (s_pend[0]),
        .addr_o        (s_addr[0]),
        .byte_enable_o (s_be[0]),
        .write_data_o  (s_wdata[0]),
        .is_write_o    (s_is_wr[0])
    );

    dram_arb_req_slot #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_slot1 (
        .clk           (clk),
        .reset_n       (reset_n),
        .sync_reset    (sync_reset),
        .addr_i        (m1_addr),
        .read_en_i     (m1_read_en),
        .write_en_i    (m1_write_en),
        .byte_enable_i (m1_byte_enable),
        .write_data_i  (m1_write_data),
        .clear_i       (ack_q[1]),
        .pending_o     (s_pend[1]),
        .addr_o        (s_addr[1]),
        .byte_enable_o (s_be[1]),
        .write_data_o  (s_wdata[1]),
        .is_write_o    (s_is_wr[1])
    );

    // Next-state and registered-output logic for grant, issue, wait and completion.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        ack_d        = '0;
        err_d        = '0;
        rdata_d      = rdata_q;
        complete_c   = 1'b0;
        timeout_c    = 1'b0;
        pick_c       = 1'b0;
        // A slot being acked this cycle still shows pending; it must not be regranted.
        req_c        = s_pend & ~ack_q;

        case (state_q)
            ARB_IDLE: begin
                if (req_c != 2'b00) begin
                    pick_c  = (req_c == 2'b11) ? ~last_grant_q : req_c[1];
                    grant_d = pick_c;
                    addr_d  = s_addr[pick_c];
                    be_d    = s_be[pick_c];
                    wdata_d = s_wdata[pick_c];
                    rd_en_d = !s_is_wr[pick_c];
                    wr_en_d = s_is_wr[pick_c];
                    state_d = ARB_ISSUE;
                end
            end
            ARB_ISSUE: begin
                // The issue cycle counts as the first watchdog cycle.
                cnt_d      = CNT_W'(1);
                state_d    = ARB_WAIT;
                complete_c = dram_ack;
            end
            ARB_WAIT: begin
                if (dram_ack) begin
                    complete_c = 1'b1;
                end else if (TO_EN && (cnt_q >= TO_LAST)) begin
                    complete_c = 1'b1;
                    timeout_c  = 1'b1;
                end else if (cnt_q < TO_MAX) begin
                    cnt_d = CNT_W'(cnt_q + 1'b1);
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        if (complete_c) begin
            state_d          = ARB_IDLE;
            ack_d[grant_q]   = 1'b1;
            err_d[grant_q]   = timeout_c;
            rdata_d[grant_q] = (timeout_c || s_is_wr[grant_q]) ? '0 : dram_mem_read_data;
            last_grant_d     = grant_q;
        end

        busy_d = (state_d != ARB_IDLE);

        if (sync_reset) begin
            state_d      = ARB_IDLE;
            grant_d      = 1'b0;
            last_grant_d = 1'b1;
            cnt_d        = '0;
            addr_d       = '0;
            be_d         = '0;
            wdata_d      = '0;
            rd_en_d      = 1'b0;
            wr_en_d      = 1'b0;
            busy_d       = 1'b0;
            ack_d        = '0;
            err_d        = '0;
            rdata_d      = '0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ARB_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            cnt_q        <= '0;
            addr_q       <= '0;
            be_q         <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            ack_q        <= '0;
            err_q        <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    assign m0_pending           = s_pend[0];
    assign m1_pending           = s_pend[1];
    assign m0_ack               = ack_q[0];
    assign m1_ack               = ack_q[1];
    assign m0_err               = err_q[0];
    assign m1_err               = err_q[1];
    assign m0_read_data         = rdata_q[0];
    assign m1_read_data         = rdata_q[1];
    assign dram_mem_addr        = addr_q;
    assign dram_mem_read_en     = rd_en_q;
    assign dram_mem_write_en    = wr_en_q;
    assign dram_mem_byte_enable = be_q;
    assign dram_mem_write_data  = wdata_q;
    assign busy                 = busy_q;

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench for dram_port_arbiter (watchdog shortened to 8 cycles).
module tb_dram_port_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = DW / 8;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sync_reset = 1'b0;
    logic [AW-1:0] m0_addr, m1_addr;
    logic          m0_read_en, m0_write_en, m1_read_en, m1_write_en;
    logic [BW-1:0] m0_byte_enable, m1_byte_enable;
    logic [DW-1:0] m0_write_data, m1_write_data;
    logic          m0_pending, m0_ack, m0_err, m1_pending, m1_ack, m1_err;
    logic [DW-1:0] m0_read_data, m1_read_data;
    logic          dram_ack;
    logic [DW-1:0] dram_mem_read_data;
    logic [AW-1:0] dram_mem_addr;
    logic          dram_mem_read_en, dram_mem_write_en;
    logic [BW-1:0] dram_mem_byte_enable;
    logic [DW-1:0] dram_mem_write_data;
    logic          busy;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          we;
        logic [BW-1:0] be;
        logic [DW-1:0] wdata;
    } dram_t;

    typedef struct packed {
        logic          master;
        logic          err;
        logic [DW-1:0] rdata;
    } ack_t;

    typedef struct {
        bit    strobe_seen;
        int    sdelay;
        dram_t d;
        bit    hold_ok;
        bit    ack_seen;
        int    adelay;
        ack_t  a;
    } obs_t;

    dram_t exp_dram_q[$];
    ack_t  exp_ack_q[$];
    int    tests = 0;
    int    fails = 0;

    dram_port_arbiter #(
        .TIMEOUT_CYCLES (8),
        .ADDR_W         (AW),
        .DATA_W         (DW)
    ) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .sync_reset           (sync_reset),
        .m0_addr              (m0_addr),
        .m0_read_en           (m0_read_en),
        .m0_write_en          (m0_write_en),
        .m0_byte_enable       (m0_byte_enable),
        .m0_write_data        (m0_write_data),
        .m0_pending           (m0_pending),
        .m0_ack               (m0_ack),
        .m0_err               (m0_err),
        .m0_read_data         (m0_read_data),
        .m1_addr              (m1_addr),
        .m1_read_en           (m1_read_en),
        .m1_write_en          (m1_write_en),
        .m1_byte_enable       (m1_byte_enable),
        .m1_write_data        (m1_write_data),
        .m1_pending           (m1_pending),
        .m1_ack               (m1_ack),
        .m1_err               (m1_err),
        .m1_read_data         (m1_read_data),
        .dram_ack             (dram_ack),
        .dram_mem_read_data   (dram_mem_read_data),
        .dram_mem_addr        (dram_mem_addr),
        .dram_mem_read_en     (dram_mem_read_en),
        .dram_mem_write_en    (dram_mem_write_en),
        .dram_mem_byte_enable (dram_mem_byte_enable),
        .dram_mem_write_data  (dram_mem_write_data),
        .busy                 (busy)
    );

    always #5 clk = ~clk;

    // Advance one cycle; DUT registers are settled when this returns.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input bit k, input bit rd, input bit wr, input logic [AW-1:0] a,
                           input logic [BW-1:0] be, input logic [DW-1:0] wd);
        if (k == 1'b0) begin
            m0_read_en = rd; m0_write_en = wr; m0_addr = a; m0_byte_enable = be; m0_write_data = wd;
        end else begin
            m1_read_en = rd; m1_write_en = wr; m1_addr = a; m1_byte_enable = be; m1_write_data = wd;
        end
    endtask

    task automatic clear_reqs();
        m0_read_en = 1'b0; m0_write_en = 1'b0; m0_addr = '0; m0_byte_enable = '0; m0_write_data = '0;
        m1_read_en = 1'b0; m1_write_en = 1'b0; m1_addr = '0; m1_byte_enable = '0; m1_write_data = '0;
    endtask

    task automatic do_reset();
        clear_reqs();
        dram_ack = 1'b0;
        dram_mem_read_data = '0;
        sync_reset = 1'b0;
        reset_n = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
        exp_dram_q.delete();
        exp_ack_q.delete();
    endtask

    function automatic logic [255:0] outs();
        return 256'({m0_pending, m1_pending, m0_ack, m1_ack, m0_err, m1_err, m0_read_data, m1_read_data,
                     dram_mem_addr, dram_mem_read_en, dram_mem_write_en, dram_mem_byte_enable,
                     dram_mem_write_data, busy});
    endfunction

    // Waits for a strobe, answers it after lat cycles (lat < 0: never), then waits for the ack.
    task automatic observe_txn(input int lat, input logic [DW-1:0] rd, output obs_t o);
        o = '{default: 0};
        o.sdelay = -1;
        o.adelay = -1;
        o.hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (dram_mem_read_en || dram_mem_write_en) begin
                o.strobe_seen = 1'b1;
                o.sdelay = i;
                o.d = {dram_mem_addr, dram_mem_write_en, dram_mem_byte_enable, dram_mem_write_data};
                break;
            end
            step();
        end
        if (!o.strobe_seen) return;
        for (int i = 0; i < 40; i++) begin
            if (m0_ack || m1_ack) begin
                o.ack_seen = 1'b1;
                o.adelay = i;
                o.a = m1_ack ? {1'b1, m1_err, m1_read_data} : {1'b0, m0_err, m0_read_data};
                if (m0_ack && m1_ack) o.hold_ok = 1'b0;
                break;
            end
            if (i > 0 && (dram_mem_read_en || dram_mem_write_en || dram_mem_addr !== o.d.addr))
                o.hold_ok = 1'b0;
            dram_ack = (i == lat);
            dram_mem_read_data = (i == lat) ? rd : '0;
            step();
        end
        dram_ack = 1'b0;
        dram_mem_read_data = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL reset_outs: got %h want 0", outs()); end
        reset_n = 1'b1;
        step();
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL post_reset_idle: got %h want 0", outs()); end
    endtask

    task automatic test_single_read();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 16'h0100, 4'hF, 32'h0);
        exp_dram_q.push_back({16'h0100, 1'b0, 4'hF, 32'h0});
        exp_ack_q.push_back({1'b0, 1'b0, 32'hDEADBEEF});
        step();
        clear_reqs();
        tests++;
        if (m0_pending !== 1'b1) begin fails++; $display("FAIL rd_pending: got %b want 1", m0_pending); end
        observe_txn(3, 32'hDEADBEEF, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.sdelay != 1) begin fails++; $display("FAIL rd_strobe_lat: got %0d want 1", o.sdelay); end
        tests++;
        if (o.d !== e) begin fails++; $display("FAIL rd_dram: got %h want %h", o.d, e); end
        tests++;
        if (!o.hold_ok) begin fails++; $display("FAIL rd_wait_hold: got 0 want 1"); end
        tests++;
        if (o.adelay != 4) begin fails++; $display("FAIL rd_ack_lat: got %0d want 4", o.adelay); end
        tests++;
        if (o.a !== ea) begin fails++; $display("FAIL rd_ack: got %h want %h", o.a, ea); end
        // A pulse in the ack cycle is dropped; one cycle later it is accepted.
        set_req(1'b0, 1'b1, 1'b0, 16'h0104, 4'hF, 32'h0);
        step();
        clear_reqs();
        tests++;
        if ({m0_pending, busy} !== 2'b00) begin
            fails++; $display("FAIL ack_cycle_drop: got %b want 00", {m0_pending, busy});
        end
        set_req(1'b0, 1'b1, 1'b0, 16'h0108, 4'hF, 32'h0);
        exp_dram_q.push_back({16'h0108, 1'b0, 4'hF, 32'h0});
        exp_ack_q.push_back({1'b0, 1'b0, 32'h01020304});
        step();
        clear_reqs();
        observe_txn(0, 32'h01020304, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.d !== e) begin fails++; $display("FAIL retry_dram: got %h want %h", o.d, e); end
        tests++;
        if (o.a !== ea || o.adelay != 1) begin
            fails++; $display("FAIL retry_ack: got %h/%0d want %h/1", o.a, o.adelay, ea);
        end
    endtask

    task automatic test_round_robin();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        do_reset();
        for (int r = 0; r < 3; r++) begin
            if (r == 2) begin
                // Serve m0 alone so m1 wins the following tie.
                set_req(1'b0, 1'b0, 1'b1, 16'h0030, 4'hF, 32'hCCCC0000);
                exp_dram_q.push_back({16'h0030, 1'b1, 4'hF, 32'hCCCC0000});
                exp_ack_q.push_back({1'b0, 1'b0, 32'h0});
                step();
                clear_reqs();
                observe_txn(1, 32'h0, o);
                e = exp_dram_q.pop_front();
                ea = exp_ack_q.pop_front();
                tests++;
                if (o.d !== e || o.a !== ea) begin
                    fails++; $display("FAIL rr_solo: got %h/%h want %h/%h", o.d, o.a, e, ea);
                end
                step();
            end
            set_req(1'b0, 1'b0, 1'b1, AW'(16'h0010 + r), 4'hF, DW'(32'hAAAA0000 + r));
            set_req(1'b1, 1'b0, 1'b1, AW'(16'h0020 + r), 4'hF, DW'(32'hBBBB0000 + r));
            if (r < 2) begin
                exp_dram_q.push_back({AW'(16'h0010 + r), 1'b1, 4'hF, DW'(32'hAAAA0000 + r)});
                exp_dram_q.push_back({AW'(16'h0020 + r), 1'b1, 4'hF, DW'(32'hBBBB0000 + r)});
                exp_ack_q.push_back({1'b0, 1'b0, 32'h0});
                exp_ack_q.push_back({1'b1, 1'b0, 32'h0});
            end else begin
                exp_dram_q.push_back({AW'(16'h0020 + r), 1'b1, 4'hF, DW'(32'hBBBB0000 + r)});
                exp_dram_q.push_back({AW'(16'h0010 + r), 1'b1, 4'hF, DW'(32'hAAAA0000 + r)});
                exp_ack_q.push_back({1'b1, 1'b0, 32'h0});
                exp_ack_q.push_back({1'b0, 1'b0, 32'h0});
            end
            step();
            clear_reqs();
            for (int t = 0; t < 2; t++) begin
                observe_txn(1, 32'h5A5A5A5A, o);
                e = exp_dram_q.pop_front();
                ea = exp_ack_q.pop_front();
                tests++;
                if (o.sdelay != 1) begin
                    fails++; $display("FAIL rr_strobe_lat r%0d t%0d: got %0d want 1", r, t, o.sdelay);
                end
                tests++;
                if (o.d !== e) begin fails++; $display("FAIL rr_dram r%0d t%0d: got %h want %h", r, t, o.d, e); end
                tests++;
                if (o.a !== ea || o.adelay != 2) begin
                    fails++; $display("FAIL rr_ack r%0d t%0d: got %h/%0d want %h/2", r, t, o.a, o.adelay, ea);
                end
            end
            step();
        end
    endtask

    task automatic test_pending_drop();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        int    extra;
        do_reset();
        set_req(1'b1, 1'b0, 1'b1, 16'h0055, 4'b0011, 32'h12345678);
        exp_dram_q.push_back({16'h0055, 1'b1, 4'b0011, 32'h12345678});
        exp_ack_q.push_back({1'b1, 1'b0, 32'h0});
        step();
        set_req(1'b1, 1'b0, 1'b1, 16'h0066, 4'b1100, 32'h87654321);
        step();
        clear_reqs();
        observe_txn(2, 32'h99999999, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.sdelay != 0) begin fails++; $display("FAIL drop_strobe_lat: got %0d want 0", o.sdelay); end
        tests++;
        if (o.d !== e) begin fails++; $display("FAIL drop_dram: got %h want %h", o.d, e); end
        tests++;
        if (o.a !== ea) begin fails++; $display("FAIL drop_ack: got %h want %h", o.a, ea); end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (dram_mem_read_en || dram_mem_write_en || m1_pending) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL drop_second: got %0d want 0", extra); end
    endtask

    task automatic test_rw_both();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        do_reset();
        set_req(1'b0, 1'b1, 1'b1, 16'h0040, 4'hF, 32'hA5A5A5A5);
        exp_dram_q.push_back({16'h0040, 1'b1, 4'hF, 32'hA5A5A5A5});
        exp_ack_q.push_back({1'b0, 1'b0, 32'h0});
        step();
        clear_reqs();
        observe_txn(0, 32'h11111111, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.d !== e) begin fails++; $display("FAIL rw_dram: got %h want %h", o.d, e); end
        tests++;
        if (o.a !== ea) begin fails++; $display("FAIL rw_ack: got %h want %h", o.a, ea); end
    endtask

    task automatic test_timeout();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        int    extra;
        do_reset();
        set_req(1'b0, 1'b1, 1'b0, 16'h0200, 4'hF, 32'h0);
        exp_dram_q.push_back({16'h0200, 1'b0, 4'hF, 32'h0});
        exp_ack_q.push_back({1'b0, 1'b1, 32'h0});
        step();
        clear_reqs();
        observe_txn(-1, 32'h0, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.d !== e) begin fails++; $display("FAIL to_dram: got %h want %h", o.d, e); end
        tests++;
        if (o.adelay != 8) begin fails++; $display("FAIL to_latency: got %0d want 8", o.adelay); end
        tests++;
        if (o.a !== ea) begin fails++; $display("FAIL to_ack: got %h want %h", o.a, ea); end
        dram_ack = 1'b1;
        dram_mem_read_data = 32'hFEEDFACE;
        step();
        dram_ack = 1'b0;
        dram_mem_read_data = '0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (m0_ack || m1_ack || busy || m0_pending) extra++;
            step();
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL late_ack_ignored: got %0d want 0", extra); end
    endtask

    task automatic test_async_reset();
        obs_t  o;
        dram_t e;
        ack_t  ea;
        int    extra;
        do_reset();
        set_req(1'b1, 1'b1, 1'b0, 16'h0300, 4'hF, 32'h0);
        step();
        clear_reqs();
        step();
        step();
        step();
        tests++;
        if ({busy, m1_pending} !== 2'b11) begin fails++; $display("FAIL ar_in_wait: got %b want 11", {busy, m1_pending}); end
        #2;
        reset_n = 1'b0;
        #1;
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL ar_outs: got %h want 0", outs()); end
        step();
        reset_n = 1'b1;
        dram_ack = 1'b1;
        step();
        dram_ack = 1'b0;
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (m0_ack || m1_ack || m1_pending || busy) extra++;
            step();
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL ar_no_ack: got %0d want 0", extra); end
        set_req(1'b0, 1'b1, 1'b0, 16'h0310, 4'hF, 32'h0);
        exp_dram_q.push_back({16'h0310, 1'b0, 4'hF, 32'h0});
        exp_ack_q.push_back({1'b0, 1'b0, 32'hCAFEF00D});
        step();
        clear_reqs();
        observe_txn(1, 32'hCAFEF00D, o);
        e = exp_dram_q.pop_front();
        ea = exp_ack_q.pop_front();
        tests++;
        if (o.d !== e || o.sdelay != 1) begin
            fails++; $display("FAIL ar_after_dram: got %h/%0d want %h/1", o.d, o.sdelay, e);
        end
        tests++;
        if (o.a !== ea) begin fails++; $display("FAIL ar_after_ack: got %h want %h", o.a, ea); end
    endtask

    task automatic test_sync_reset();
        int extra;
        do_reset();
        set_req(1'b0, 1'b0, 1'b1, 16'h0400, 4'hF, 32'h77777777);
        step();
        clear_reqs();
        step();
        tests++;
        if (dram_mem_write_en !== 1'b1) begin fails++; $display("FAIL sr_issue: got %b want 1", dram_mem_write_en); end
        sync_reset = 1'b1;
        dram_ack = 1'b1;
        step();
        sync_reset = 1'b0;
        dram_ack = 1'b0;
        tests++;
        if (outs() !== '0) begin fails++; $display("FAIL sr_outs: got %h want 0", outs()); end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (m0_ack || m1_ack || busy || dram_mem_write_en) extra++;
        end
        tests++;
        if (extra != 0) begin fails++; $display("FAIL sr_no_ack: got %0d want 0", extra); end
    endtask

    initial begin
        clear_reqs();
        dram_ack = 1'b0;
        dram_mem_read_data = '0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_pending_drop();
        test_rw_both();
        test_timeout();
        test_async_reset();
        test_sync_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish within 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single external DRAM port between two masters.
  - Master 0 is the core-side memory controller path.
  - Master 1 is a secondary master, such as a debug loader or DMA engine.
- Captures one-cycle request pulses and arbitrates them round-robin.
- Drives one DRAM transaction at a time and returns a per-master ack with read data.
- A watchdog terminates transactions whose DRAM ack never arrives.
- Sits between the MCU top level and the DRAM interface pins.

Parameters:
- TIMEOUT_CYCLES, 1023: cycles to wait for dram_ack before forcing an error completion; 0 disables the watchdog.
- ADDR_W, `MEM_ADDR_BITS: DRAM word-address width.
- DATA_W, `XLEN: data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sync_reset  in  1  synchronous reset, same effect as reset_n
- mK_addr  in  ADDR_W  master K address (K = 0, 1)
- mK_read_en  in  1  master K read request pulse
- mK_write_en  in  1  master K write request pulse
- mK_byte_enable  in  DATA_W/8  master K byte lanes
- mK_write_data  in  DATA_W  master K write data
- mK_pending  out  1  master K request outstanding; new pulses are ignored while high
- mK_ack  out  1  master K completion pulse
- mK_err  out  1  master K timeout completion, coincident with mK_ack
- mK_read_data  out  DATA_W  master K read data, valid with mK_ack
- dram_ack  in  1  DRAM completion
- dram_mem_read_data  in  DATA_W  DRAM read data
- dram_mem_addr  out  ADDR_W  DRAM address
- dram_mem_read_en  out  1  DRAM read strobe
- dram_mem_write_en  out  1  DRAM write strobe
- dram_mem_byte_enable  out  DATA_W/8  DRAM byte lanes
- dram_mem_write_data  out  DATA_W  DRAM write data
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset:
  - Applies on reset_n low (async) or sync_reset high (sync).
  - All outputs go to 0; FSM goes to IDLE.
  - Both request slots are cleared; last_grant is set to 1, so master 0 wins the first tie.
- Capture:
  - In cycle T, mK_read_en or mK_write_en with mK_pending=0 latches the address, byte enables, data and op into slot K; mK_pending=1 from T+1.
  - Read and write asserted together: the write is captured and the read is dropped.
  - Any pulse while mK_pending=1 is ignored.
- FSM:
  - IDLE:
    - If any slot is pending, grant it.
    - If both are pending, grant the master that is not last_grant.
    - Go to ISSUE.
  - ISSUE:
    - Assert dram_mem_read_en or dram_mem_write_en for exactly this one cycle.
    - Drive addr, byte_enable and write_data from the granted slot.
    - Clear the timeout counter; go to WAIT.
    - A dram_ack in this cycle completes immediately, as in WAIT.
  - WAIT:
    - Strobes are 0; addr, byte_enable and write_data are held stable.
    - Timeout counter increments each cycle.
    - On dram_ack: in the next cycle pulse mK_ack, register mK_read_data (reads only; writes return 0), clear mK_pending, set last_grant=K, go to IDLE.
    - If the counter reaches TIMEOUT_CYCLES first: pulse mK_ack with mK_err=1, mK_read_data=0, clear the slot, go to IDLE.
- Latency:
  - Request pulse at T gives the DRAM strobe at T+2.
  - dram_ack at N gives mK_ack at N+1.
  - The next grant's strobe appears no earlier than N+2.
- Boundary conditions:
  - dram_ack in IDLE (late ack after a timeout, or spurious) is ignored.
  - A request from the master being completed, arriving in its ack cycle, is ignored because pending is still 1. It is accepted from the following cycle.
  - The other master's slot may be captured in any state.
  - Reset mid-transaction abandons it; no ack is issued.
  - TIMEOUT_CYCLES=0 waits forever.
  - Timeout counter width is clog2(TIMEOUT_CYCLES+1) and it never wraps.

Decomposition:
- `MEM_ADDR_BITS, `XLEN, `XLEN_BYTES come from common.vh.
- Add to common.vh: FSM state encodings (IDLE, ISSUE, WAIT) and DRAM_ARB_TIMEOUT_DEFAULT.
- Sub-module dram_arb_req_slot: one request capture register with pending flag, instantiated twice.

Test Plan:
- m0 read addr 0x100, dram_ack 3 cycles after the strobe with data 0xDEADBEEF -> dram_mem_read_en at T+2 with addr 0x100; m0_ack and m0_read_data=0xDEADBEEF one cycle after the ack; m0_err=0.
- m0 write and m1 write in the same cycle, after reset -> m0 is served first, m1 strobe follows m0_ack by 1 cycle. Repeat with both pending again -> m0 first (last_grant=1). Alternation continues.
- m1 write with byte_enable 4'b0011 and data 0x12345678, second m1 pulse while pending -> exactly one DRAM write with be 0011; second pulse dropped.
- TIMEOUT_CYCLES=8, no dram_ack -> m0_ack with m0_err=1, read_data 0, 8 cycles after the strobe. A late dram_ack in IDLE produces no ack.
- reset_n pulsed low during WAIT -> all outputs 0 immediately; pending cleared; no ack. A new request after reset is served normally.
- sync_reset asserted during ISSUE -> same state as reset_n on the next edge.
